tile_resolve_writer: RTL

//  Drain-side partner of tile_buffer_ctrl. Pulls the per-sample color stream over the tile

---
 rtl/tile_resolve_writer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/tile_resolve_writer.sv
// tile_resolve_writer
//   Drains a tile buffer's per-sample colour stream, box-filters SAMPLES samples
//   into one RGBA8 pixel and writes the pixels out as BURST_LEN-beat linear bursts.
//   When the whole tile has been written, it acknowledges the tile buffer's eviction
//   request.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             1-cycle pulse; ignored while busy
//   tile_base, pitch  tile byte address and surface pitch in pixels (latched on start)
//   busy, done        busy from accepted start until the done pulse
//   err_seq           sticky read-sequence error, cleared on accepted start
//   rd_req/rd_valid   sample stream handshake; rd_color/rd_addr carry the sample
//   evict_req/ack     eviction handshake with the tile buffer
//   mem_wr_*          write-burst stream (valid/ready, addr, data, last)
//
// state | meaning
// IDLE  | waiting for start
// FETCH | pulling samples, resolving pixels into the burst buffer
// WRITE | emitting one burst from the burst buffer
// ACK   | tile written, waiting for evict_req
module tile_resolve_writer #(
  parameter int TILE_W    = 16,
  parameter int TILE_H    = 16,
  parameter int SAMPLES   = 4,
  parameter int COLOR_W   = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  tile_base,
  input  logic [15:0]        pitch,
  output logic               busy,
  output logic               done,
  output logic               err_seq,
  output logic               rd_req,
  input  logic               rd_valid,
  input  logic [COLOR_W-1:0] rd_color,
  input  logic [31:0]        rd_addr,
  input  logic               evict_req,
  output logic               evict_ack,
  output logic               mem_wr_valid,
  input  logic               mem_wr_ready,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [COLOR_W-1:0] mem_wr_data,
  output logic               mem_wr_last
);
  localparam int LOG2S  = $clog2(SAMPLES);
  localparam int ACC_W  = 8 + LOG2S;
  localparam int SCNT_W = (LOG2S > 0) ? LOG2S : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int X_W    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int Y_W    = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int NCH    = 4;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, ACK} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  base_q;
  logic [15:0]        pitch_q;
  logic [ACC_W-1:0]   acc [NCH];
  logic [ACC_W-1:0]   sum [NCH];
  logic [SCNT_W-1:0]  samp_cnt;
  logic [31:0]        cell_cnt;
  logic [BEAT_W-1:0]  pix_cnt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  next_beat;
  logic [COLOR_W-1:0] pix_buf [BURST_LEN];
  logic [X_W-1:0]     px0;
  logic [Y_W-1:0]     py;
  logic [COLOR_W-1:0] resolved;
  logic [COLOR_W-1:0] first_pix;
  logic [ADDR_W-1:0]  wr_offset;
  logic [ADDR_W-1:0]  wr_addr_next;
  logic               xfer;
  logic               pix_last;
  logic               burst_full;
  logic               row_end;
  logic               tile_last;

  assign xfer       = (state == FETCH) && rd_req && rd_valid;
  assign pix_last   = (samp_cnt == SCNT_W'(SAMPLES - 1));
  assign burst_full = (pix_cnt == BEAT_W'(BURST_LEN - 1));
  assign next_beat  = beat_cnt + BEAT_W'(1);
  assign row_end    = (px0 == X_W'(TILE_W - BURST_LEN));
  assign tile_last  = row_end && (py == Y_W'(TILE_H - 1));
  assign wr_offset  = ADDR_W'(py) * ADDR_W'(pitch_q) + ADDR_W'(px0);
  assign wr_addr_next = base_q + (wr_offset << 2);
  // With single-pixel bursts the pixel lands in the buffer on the same edge the
  // burst starts, so the first beat must bypass the buffer.
  assign first_pix  = (BURST_LEN == 1) ? resolved : pix_buf[0];

  // Rounded box filter: (sum + SAMPLES/2) / SAMPLES per channel, using the
  // in-flight sample so the pixel is ready on the edge its last sample arrives.
  always_comb begin
    resolved = '0;
    for (int c = 0; c < NCH; c++) begin
      sum[c] = acc[c] + ACC_W'(rd_color[8*c +: 8]);
      resolved[8*c +: 8] = 8'((sum[c] + ACC_W'(SAMPLES / 2)) >> LOG2S);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_seq      <= 1'b0;
      rd_req       <= 1'b0;
      evict_ack    <= 1'b0;
      mem_wr_valid <= 1'b0;
      mem_wr_last  <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      base_q       <= '0;
      pitch_q      <= '0;
      samp_cnt     <= '0;
      cell_cnt     <= '0;
      pix_cnt      <= '0;
      beat_cnt     <= '0;
      px0          <= '0;
      py           <= '0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
      for (int b = 0; b < BURST_LEN; b++) pix_buf[b] <= '0;
    end else begin
      done      <= 1'b0;
      evict_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= tile_base;
            pitch_q  <= pitch;
            err_seq  <= 1'b0;
            busy     <= 1'b1;
            rd_req   <= 1'b1;
            cell_cnt <= '0;
            samp_cnt <= '0;
            pix_cnt  <= '0;
            px0      <= '0;
            py       <= '0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (xfer) begin
            cell_cnt <= cell_cnt + 32'd1;
            if (rd_addr != cell_cnt) err_seq <= 1'b1;
            if (pix_last) begin
              samp_cnt <= '0;
              for (int c = 0; c < NCH; c++) acc[c] <= '0;
              pix_buf[pix_cnt] <= resolved;
              if (burst_full) begin
                pix_cnt      <= '0;
                rd_req       <= 1'b0;
                beat_cnt     <= '0;
                mem_wr_valid <= 1'b1;
                mem_wr_addr  <= wr_addr_next;
                mem_wr_data  <= first_pix;
                mem_wr_last  <= (BURST_LEN == 1);
                state        <= WRITE;
              end else begin
                pix_cnt <= pix_cnt + BEAT_W'(1);
              end
            end else begin
              samp_cnt <= samp_cnt + SCNT_W'(1);
              for (int c = 0; c < NCH; c++) acc[c] <= sum[c];
            end
          end
        end
        WRITE: begin
          // mem_wr_valid is high throughout WRITE, so ready alone accepts a beat.
          if (mem_wr_ready) begin
            if (mem_wr_last) begin
              mem_wr_valid <= 1'b0;
              mem_wr_last  <= 1'b0;
              if (tile_last) begin
                state <= ACK;
              end else begin
                rd_req <= 1'b1;
                state  <= FETCH;
                if (row_end) begin
                  px0 <= '0;
                  py  <= py + Y_W'(1);
                end else begin
                  px0 <= px0 + X_W'(BURST_LEN);
                end
              end
            end else begin
              beat_cnt    <= next_beat;
              mem_wr_data <= pix_buf[next_beat];
              mem_wr_last <= (next_beat == BEAT_W'(BURST_LEN - 1));
            end
          end
        end
        ACK: begin
          if (evict_req) begin
            evict_ack <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
